// File: rtl/gfx256_fragment.sv
// Fragment stage: accepts one pixel from the clipper, optionally fetches and colour-keys
// a texel, then hands the pixel to the blender and acknowledges it upstream.
module gfx256_fragment #(
   parameter int point_width = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   texture_enable_i,
   input  logic                   colorkey_enable_i,
   input  logic [31:0]            colorkey_i,
   input  logic [31:0]            tex0_base_i,
   input  logic [point_width-1:0] tex0_size_x_i,
   input  logic [point_width-1:0] tex0_size_y_i,
   input  logic [point_width-1:0] pixel_x_i,
   input  logic [point_width-1:0] pixel_y_i,
   input  logic [point_width-1:0] pixel_z_i,
   input  logic [point_width-1:0] u_i,
   input  logic [point_width-1:0] v_i,
   input  logic [7:0]             a_i,
   input  logic [31:0]            color_i,
   input  logic                   write_i,
   output logic                   ack_o,
   output logic                   tex_request_o,
   output logic [31:0]            tex_addr_o,
   input  logic                   tex_ack_i,
   input  logic [31:0]            tex_data_i,
   input  logic                   wbm_busy_i,
   output logic [point_width-1:0] pixel_x_o,
   output logic [point_width-1:0] pixel_y_o,
   output logic [point_width-1:0] pixel_z_o,
   output logic [7:0]             a_o,
   output logic [31:0]            color_o,
   output logic                   write_o,
   input  logic                   ack_i
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TEX_ADDR = 2'd1,
      TEX_READ = 2'd2,
      WRITE    = 2'd3
   } state_e;

   state_e state_q, state_d;

   logic [point_width-1:0] pixel_x_q, pixel_x_d;
   logic [point_width-1:0] pixel_y_q, pixel_y_d;
   logic [point_width-1:0] pixel_z_q, pixel_z_d;
   logic [7:0]             a_q, a_d;
   logic [31:0]            color_q, color_d;
   logic                   write_q, write_d;
   logic                   ack_q, ack_d;
   logic                   tex_request_q, tex_request_d;
   logic [31:0]            tex_addr_q, tex_addr_d;
   logic [point_width-1:0] u_q, u_d;
   logic [point_width-1:0] v_q, v_d;
   logic [point_width-1:0] size_x_q, size_x_d;
   logic [31:0]            base_q, base_d;

   logic accept;
   logic tex_done;
   logic key_hit;

   // Clamp a texture coordinate to the last texel; an empty texture pins it to 0.
   function automatic logic [point_width-1:0] clamp_coord(
      input logic [point_width-1:0] coord,
      input logic [point_width-1:0] size
   );
      if (size == '0) begin
         return '0;
      end
      if (coord >= size) begin
         return size - point_width'(1);
      end
      return coord;
   endfunction

   // The cycle that carries ack_o is the upstream's release cycle, so write_i is ignored then.
   assign accept   = (state_q == IDLE) && write_i && !ack_q;
   assign tex_done = (state_q == TEX_READ) && tex_request_q && tex_ack_i;
   assign key_hit  = colorkey_enable_i && (tex_data_i == colorkey_i);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: a default for every comb output first, so no path can infer a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (accept) state_d = texture_enable_i ? TEX_ADDR : WRITE;
         TEX_ADDR: state_d = TEX_READ;
         TEX_READ: if (tex_done) state_d = key_hit ? IDLE : WRITE;
         WRITE:    if (ack_i) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      pixel_x_d     = pixel_x_q;
      pixel_y_d     = pixel_y_q;
      pixel_z_d     = pixel_z_q;
      a_d           = a_q;
      color_d       = color_q;
      write_d       = write_q;
      ack_d         = 1'b0;
      tex_request_d = tex_request_q;
      tex_addr_d    = tex_addr_q;
      u_d           = u_q;
      v_d           = v_q;
      size_x_d      = size_x_q;
      base_d        = base_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               pixel_x_d = pixel_x_i;
               pixel_y_d = pixel_y_i;
               pixel_z_d = pixel_z_i;
               a_d       = a_i;
               if (texture_enable_i) begin
                  u_d      = clamp_coord(u_i, tex0_size_x_i);
                  v_d      = clamp_coord(v_i, tex0_size_y_i);
                  size_x_d = tex0_size_x_i;
                  base_d   = tex0_base_i;
               end else begin
                  color_d = color_i;
                  write_d = 1'b1;
               end
            end
         end
         TEX_ADDR: begin
            // Texels are 32 bits; the byte address wraps at 32 bits.
            tex_addr_d = base_q + ((32'(v_q) * 32'(size_x_q) + 32'(u_q)) << 2);
         end
         TEX_READ: begin
            if (tex_done) begin
               tex_request_d = 1'b0;
               if (key_hit) begin
                  ack_d = 1'b1;
               end else begin
                  color_d = tex_data_i;
                  write_d = 1'b1;
               end
            end else if (!tex_request_q && !wbm_busy_i) begin
               tex_request_d = 1'b1;
            end
         end
         WRITE: begin
            if (ack_i) begin
               write_d = 1'b0;
               ack_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         pixel_z_q     <= '0;
         a_q           <= '0;
         color_q       <= '0;
         write_q       <= 1'b0;
         ack_q         <= 1'b0;
         tex_request_q <= 1'b0;
         tex_addr_q    <= '0;
         u_q           <= '0;
         v_q           <= '0;
         size_x_q      <= '0;
         base_q        <= '0;
      end else begin
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
         pixel_z_q     <= pixel_z_d;
         a_q           <= a_d;
         color_q       <= color_d;
         write_q       <= write_d;
         ack_q         <= ack_d;
         tex_request_q <= tex_request_d;
         tex_addr_q    <= tex_addr_d;
         u_q           <= u_d;
         v_q           <= v_d;
         size_x_q      <= size_x_d;
         base_q        <= base_d;
      end
   end

   assign pixel_x_o     = pixel_x_q;
   assign pixel_y_o     = pixel_y_q;
   assign pixel_z_o     = pixel_z_q;
   assign a_o           = a_q;
   assign color_o       = color_q;
   assign write_o       = write_q;
   assign ack_o         = ack_q;
   assign tex_request_o = tex_request_q;
   assign tex_addr_o    = tex_addr_q;

endmodule

// File: doc/gfx256_fragment.md
GFX256_FRAGMENT -- requirements
Module: gfx256_fragment

Interface
REQ-001 SHALL provide parameter point_width, default 16: width of coordinate and texture-coordinate ports.
REQ-002 SHALL have ports: clk_i  in  1  clock; all state changes on its rising edge.
REQ-003 SHALL have rst_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have configuration inputs: texture_enable_i 1; colorkey_enable_i 1; colorkey_i 32; tex0_base_i 32 (byte address); tex0_size_x_i, tex0_size_y_i point_width.
REQ-005 SHALL have upstream (clip) inputs: pixel_x_i, pixel_y_i, pixel_z_i, u_i, v_i point_width; a_i 8; color_i 32; write_i 1. Output ack_o 1, which pulses when the pixel is retired.
REQ-006 SHALL have texture read port: tex_request_o out 1; tex_addr_o out 32; tex_ack_i in 1; tex_data_i in 32 (one texel); wbm_busy_i in 1.
REQ-007 SHALL have downstream (blender) outputs: pixel_x_o, pixel_y_o, pixel_z_o point_width; a_o 8; color_o 32; write_o 1. Input ack_i 1.

Function
REQ-008 SHALL implement states IDLE, TEX_ADDR, TEX_READ, WRITE.
REQ-009 In IDLE, SHALL accept a pixel when write_i=1 and ack_o=0. Acceptance latches pixel_x/y/z_i to pixel_x/y/z_o and a_i to a_o.
REQ-010 On accept with texture_enable_i=0, SHALL load color_o<=color_i and write_o<=1 and go to WRITE. write_o is high in the cycle after the write_i edge.
REQ-011 On accept with texture_enable_i=1, SHALL go to TEX_ADDR. Effective u = min(u_i, tex0_size_x_i-1); effective v = min(v_i, tex0_size_y_i-1), both unsigned.
REQ-012 In TEX_ADDR, SHALL register tex_addr_o = tex0_base_i + ((v*tex0_size_x_i + u) << 2), computed at 32 bits with wrap-around, then go to TEX_READ.
REQ-013 In TEX_READ, SHALL assert tex_request_o when wbm_busy_i=0. Once asserted, tex_request_o SHALL hold until tex_ack_i regardless of wbm_busy_i. tex_addr_o SHALL stay stable throughout.
REQ-014 On tex_ack_i, SHALL deassert tex_request_o and sample tex_data_i. If colorkey_enable_i=1 and tex_data_i==colorkey_i: discard, pulse ack_o for one cycle, go to IDLE, leave write_o low. Otherwise: color_o<=tex_data_i, write_o<=1, go to WRITE.
REQ-015 In WRITE, SHALL hold write_o and all pixel outputs stable until ack_i. On the ack_i edge: write_o<=0, ack_o<=1 for exactly one cycle, go to IDLE.
REQ-016 ack_o SHALL be a single-cycle registered pulse, exactly one per accepted pixel.
REQ-017 write_i seen in the cycle where ack_o=1 SHALL be ignored; this covers the one-cycle upstream release delay.
REQ-018 ack_i while write_o=0 and tex_ack_i outside TEX_READ SHALL be ignored.
REQ-019 Configuration inputs SHALL be sampled only at acceptance or in TEX_ADDR. Changes mid-pixel SHALL not affect that pixel's address or colorkey decision, except colorkey_i/colorkey_enable_i, which are sampled at tex_ack_i.
REQ-020 tex0_size_x_i=0 or tex0_size_y_i=0 SHALL clamp the corresponding coordinate to 0.

Reset
REQ-021 While rst_i=0, state SHALL be IDLE and all outputs SHALL be 0: write_o, ack_o, tex_request_o, tex_addr_o, color_o, a_o, pixel_x/y/z_o.
REQ-022 Reset asserted mid-operation SHALL abandon the pixel with no ack_o and drop tex_request_o immediately. After release, the block SHALL wait for a new write_i.

Verification
REQ-023 Untextured: color_i=0x00FF0000, (x,y)=(10,20), write_i -> next cycle write_o=1, color_o=0x00FF0000, pixel_x_o=10. ack_i 3 cycles later -> write_o=0 and one ack_o pulse on the same edge.
REQ-024 Textured: tex0_base_i=0x1000, size_x=64, u=3, v=2 -> tex_addr_o=0x120C. tex_request_o rises 2 cycles after accept. tex_ack_i with data 0x12345678 -> write_o=1, color_o=0x12345678.
REQ-025 Colorkey: colorkey_enable_i=1, colorkey_i=0xFF00FF00, texel=0xFF00FF00 -> write_o stays 0; one ack_o pulse the cycle after tex_ack_i.
REQ-026 Busy/clamp: wbm_busy_i=1 for 5 cycles in TEX_READ -> tex_request_o stays 0, then rises the cycle after busy falls. u=70, size_x=64, v=0, base 0 -> tex_addr_o=0xFC.
REQ-027 Back-to-back: upstream keeps write_i high one cycle after ack_o -> no second accept; total ack_o pulses equals pixels sent.
REQ-028 Reset mid-read: rst_i low while tex_request_o=1 -> all outputs 0 asynchronously, no ack_o. After release, a new pixel completes normally.
